// File: rtl/irig_pkg.sv
// rtl/irig_pkg.sv - shared state encoding and calendar helpers for the IRIG sync path
package irig_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED,
        HOLDOVER
    } sync_state_t;

    localparam int SEC_PER_DAY = 86400;

    function automatic logic [8:0] days_in_year(input logic [6:0] year);
        return (year[1:0] == 2'd0) ? 9'd366 : 9'd365;
    endfunction

endpackage

// File: rtl/irig_ts_advance.sv
// rtl/irig_ts_advance.sv - combinational one-second advance of (sec, day, year)
module irig_ts_advance
    import irig_pkg::*;
(
    input  logic [16:0] sec,
    input  logic [8:0]  day,
    input  logic [6:0]  year,
    output logic [16:0] sec_next,
    output logic [8:0]  day_next,
    output logic [6:0]  year_next
);

    always_comb begin
        sec_next  = sec + 17'd1;
        day_next  = day;
        year_next = year;
        if (sec >= 17'(SEC_PER_DAY - 1)) begin
            sec_next = '0;
            if (day >= days_in_year(year)) begin
                day_next  = 9'd1;
                year_next = (year >= 7'd99) ? 7'd0 : year + 7'd1;
            end else begin
                day_next = day + 9'd1;
            end
        end
    end

endmodule

// File: rtl/irig_sync_ctrl.sv
// rtl/irig_sync_ctrl.sv - PPS/timestamp qualification with acquire, lock and holdover sequencing
module irig_sync_ctrl
    import irig_pkg::*;
#(
    parameter int CLK_HZ    = 10000000,
    parameter int PPS_TOL   = 1000,
    parameter int ACQ_COUNT = 3,
    parameter int HOLD_MAX  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pps_in,
    input  logic [16:0] ts_sec_day_in,
    input  logic [8:0]  ts_day_in,
    input  logic [6:0]  ts_year_in,
    output logic        pps_out,
    output logic [16:0] ts_sec_day,
    output logic [8:0]  ts_day,
    output logic [6:0]  ts_year,
    output logic        locked,
    output logic        holdover,
    output logic [7:0]  err_cnt
);

    localparam int PH_W = $clog2(CLK_HZ + PPS_TOL + 1);
    localparam int GC_W = $clog2(ACQ_COUNT + 1);
    localparam int HC_W = $clog2(HOLD_MAX + 1);

    localparam logic [PH_W-1:0] PH_SAT    = PH_W'(CLK_HZ + PPS_TOL);
    localparam logic [PH_W-1:0] PH_LATE   = PH_W'(CLK_HZ + PPS_TOL - 1);
    localparam logic [PH_W-1:0] PH_WIN_LO = PH_W'(CLK_HZ - PPS_TOL - 1);
    localparam logic [PH_W-1:0] PH_GRID   = PH_W'(CLK_HZ - 1);
    localparam logic [PH_W-1:0] PH_EARLY  = PH_W'(CLK_HZ - PPS_TOL);
    localparam logic [PH_W-1:0] PH_TOL    = PH_W'(PPS_TOL);
    localparam logic [GC_W-1:0] GC_LAST   = GC_W'(ACQ_COUNT - 1);
    localparam logic [HC_W-1:0] HC_FULL   = HC_W'(HOLD_MAX);

    sync_state_t     state;
    logic [PH_W-1:0] ph;
    logic [GC_W-1:0] good_cnt;
    logic [HC_W-1:0] hold_cnt;
    logic [16:0]     ref_sec;
    logic [8:0]      ref_day;
    logic [6:0]      ref_year;
    logic [16:0]     adv_sec;
    logic [8:0]      adv_day;
    logic [6:0]      adv_year;
    logic            good;
    logic            early_ok;
    logic            late_ok;
    logic            rej;

    // ref_* tracks the last real timestamp, and in holdover mirrors ts_* so one
    // incrementer serves both the sequence check and the free-running advance.
    irig_ts_advance u_adv (
        .sec       (ref_sec),
        .day       (ref_day),
        .year      (ref_year),
        .sec_next  (adv_sec),
        .day_next  (adv_day),
        .year_next (adv_year)
    );

    assign good     = pps_in && (ph >= PH_WIN_LO) && (ph <= PH_LATE) && (ts_sec_day_in == adv_sec);
    assign early_ok = pps_in && (ph >= PH_EARLY) && (ts_sec_day_in == adv_sec);
    assign late_ok  = pps_in && (ph <= PH_TOL) && (ts_sec_day_in == ref_sec);

    always_comb begin
        rej = 1'b0;
        case (state)
            ACQUIRE, LOCKED: rej = pps_in && !good;
            HOLDOVER:        rej = pps_in && !early_ok && !late_ok;
            default:         rej = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (rej && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            ph         <= '0;
            good_cnt   <= '0;
            hold_cnt   <= '0;
            ref_sec    <= '0;
            ref_day    <= '0;
            ref_year   <= '0;
            pps_out    <= 1'b0;
            ts_sec_day <= '0;
            ts_day     <= '0;
            ts_year    <= '0;
            locked     <= 1'b0;
            holdover   <= 1'b0;
        end else begin
            pps_out <= 1'b0;
            ph      <= (ph == PH_SAT) ? ph : ph + 1'b1;
            case (state)
                SEARCH: begin
                    if (pps_in) begin
                        ref_sec  <= ts_sec_day_in;
                        ref_day  <= ts_day_in;
                        ref_year <= ts_year_in;
                        ph       <= '0;
                        good_cnt <= '0;
                        state    <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (pps_in) begin
                        ref_sec  <= ts_sec_day_in;
                        ref_day  <= ts_day_in;
                        ref_year <= ts_year_in;
                    end
                    if (good) begin
                        ph <= '0;
                        if (good_cnt == GC_LAST) begin
                            good_cnt <= '0;
                            state    <= LOCKED;
                            locked   <= 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end else begin
                        if (pps_in) good_cnt <= '0;
                        if (ph >= PH_LATE) state <= SEARCH;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        ref_sec    <= ts_sec_day_in;
                        ref_day    <= ts_day_in;
                        ref_year   <= ts_year_in;
                        ts_sec_day <= ts_sec_day_in;
                        ts_day     <= ts_day_in;
                        ts_year    <= ts_year_in;
                        pps_out    <= 1'b1;
                        ph         <= '0;
                    end else if (ph >= PH_LATE) begin
                        // Restarting at PPS_TOL puts the next grid point 2*CLK_HZ after the last real pulse.
                        ref_sec    <= adv_sec;
                        ref_day    <= adv_day;
                        ref_year   <= adv_year;
                        ts_sec_day <= adv_sec;
                        ts_day     <= adv_day;
                        ts_year    <= adv_year;
                        pps_out    <= 1'b1;
                        ph         <= PH_TOL;
                        hold_cnt   <= HC_W'(1);
                        state      <= HOLDOVER;
                        locked     <= 1'b0;
                        holdover   <= 1'b1;
                    end
                end
                HOLDOVER: begin
                    if (early_ok || late_ok) begin
                        ref_sec  <= ts_sec_day_in;
                        ref_day  <= ts_day_in;
                        ref_year <= ts_year_in;
                        ph       <= '0;
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        holdover <= 1'b0;
                        if (early_ok) begin
                            ts_sec_day <= ts_sec_day_in;
                            ts_day     <= ts_day_in;
                            ts_year    <= ts_year_in;
                            pps_out    <= 1'b1;
                        end
                    end else if (ph == PH_GRID) begin
                        ph <= '0;
                        if (hold_cnt >= HC_FULL) begin
                            state    <= SEARCH;
                            holdover <= 1'b0;
                        end else begin
                            ref_sec    <= adv_sec;
                            ref_day    <= adv_day;
                            ref_year   <= adv_year;
                            ts_sec_day <= adv_sec;
                            ts_day     <= adv_day;
                            ts_year    <= adv_year;
                            pps_out    <= 1'b1;
                            hold_cnt   <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_irig_sync_ctrl.sv
// tb/tb_irig_sync_ctrl.sv - directed self-checking bench for irig_sync_ctrl
module tb_irig_sync_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pps_in = 1'b0;
    logic [16:0] ts_sec_day_in = '0;
    logic [8:0]  ts_day_in = '0;
    logic [6:0]  ts_year_in = '0;
    logic        pps_out;
    logic [16:0] ts_sec_day;
    logic [8:0]  ts_day;
    logic [6:0]  ts_year;
    logic        locked;
    logic        holdover;
    logic [7:0]  err_cnt;

    int checks = 0;
    int passed = 0;
    int pps_cnt = 0;
    int dbl_cnt = 0;
    logic prev_pps = 1'b0;

    always #5 clk = ~clk;

    irig_sync_ctrl #(
        .CLK_HZ   (1000),
        .PPS_TOL  (10),
        .ACQ_COUNT(3),
        .HOLD_MAX (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pps_in        (pps_in),
        .ts_sec_day_in (ts_sec_day_in),
        .ts_day_in     (ts_day_in),
        .ts_year_in    (ts_year_in),
        .pps_out       (pps_out),
        .ts_sec_day    (ts_sec_day),
        .ts_day        (ts_day),
        .ts_year       (ts_year),
        .locked        (locked),
        .holdover      (holdover),
        .err_cnt       (err_cnt)
    );

    always @(negedge clk) begin
        if (pps_out === 1'b1) pps_cnt++;
        if (pps_out === 1'b1 && prev_pps === 1'b1) dbl_cnt++;
        prev_pps = pps_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pps_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input int s, input int d, input int y);
        pps_in = 1'b1;
        ts_sec_day_in = 17'(s);
        ts_day_in = 9'(d);
        ts_year_in = 7'(y);
        tick();
        pps_in = 1'b0;
    endtask

    task automatic lock_seq(input int s, input int d, input int y);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (999) tick();
            pulse(s - 3 + i, d, y);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (pps_out !== 1'b0) $display("FAIL reset_pps: got %0b want 0", pps_out); else passed++;
        checks++; if ({ts_sec_day, ts_day, ts_year} !== 33'd0) $display("FAIL reset_ts: got %0d/%0d/%0d want 0/0/0", ts_sec_day, ts_day, ts_year); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else passed++;
        checks++; if (holdover !== 1'b0) $display("FAIL reset_holdover: got %0b want 0", holdover); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_cnt); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_acquire();
        int base;
        do_reset();
        base = pps_cnt;
        pulse(100, 50, 23);
        repeat (999) tick();
        pulse(101, 50, 23);
        repeat (999) tick();
        pulse(102, 50, 23);
        checks++; if (locked !== 1'b0) $display("FAIL acq_early_lock: got %0b want 0", locked); else passed++;
        repeat (999) tick();
        pulse(103, 50, 23);
        checks++; if (locked !== 1'b1) $display("FAIL acq_locked: got %0b want 1", locked); else passed++;
        checks++; if (pps_out !== 1'b0) $display("FAIL acq_no_pps: got %0b want 0", pps_out); else passed++;
        repeat (999) tick();
        pulse(104, 50, 23);
        checks++; if (pps_out !== 1'b1) $display("FAIL acq_pps_follow: got %0b want 1", pps_out); else passed++;
        checks++; if ({ts_sec_day, ts_day} !== {17'd104, 9'd50}) $display("FAIL acq_ts: got %0d/%0d want 104/50", ts_sec_day, ts_day); else passed++;
        tick();
        checks++; if (pps_out !== 1'b0) $display("FAIL acq_pps_single: got %0b want 0", pps_out); else passed++;
        checks++; if (pps_cnt - base !== 1) $display("FAIL acq_pps_count: got %0d want 1", pps_cnt - base); else passed++;
    endtask

    task automatic test_window();
        do_reset();
        pulse(200, 60, 23);
        repeat (999) tick();
        pulse(201, 60, 23);
        repeat (984) tick();
        pulse(202, 60, 23);
        checks++; if (err_cnt !== 8'd1) $display("FAIL win_reject: got %0d want 1", err_cnt); else passed++;
        repeat (4) tick();
        pulse(203, 60, 23);
        repeat (999) tick();
        pulse(204, 60, 23);
        checks++; if (locked !== 1'b0) $display("FAIL win_goodcnt_cleared: got %0b want 0", locked); else passed++;
        repeat (999) tick();
        pulse(205, 60, 23);
        checks++; if (locked !== 1'b1) $display("FAIL win_edge_accept: got %0b want 1", locked); else passed++;
        checks++; if (err_cnt !== 8'd1) $display("FAIL win_err_stable: got %0d want 1", err_cnt); else passed++;
    endtask

    task automatic test_holdover();
        lock_seq(500, 100, 23);
        repeat (1009) tick();
        checks++; if (pps_out !== 1'b0) $display("FAIL hold_not_early: got %0b want 0", pps_out); else passed++;
        tick();
        checks++; if (pps_out !== 1'b1) $display("FAIL hold_first_pps: got %0b want 1", pps_out); else passed++;
        checks++; if ({ts_sec_day, ts_day, ts_year} !== {17'd501, 9'd100, 7'd23}) $display("FAIL hold_first_ts: got %0d/%0d/%0d want 501/100/23", ts_sec_day, ts_day, ts_year); else passed++;
        checks++; if ({holdover, locked} !== 2'b10) $display("FAIL hold_flags: got holdover=%0b locked=%0b want 1/0", holdover, locked); else passed++;
        repeat (989) tick();
        checks++; if (pps_out !== 1'b0) $display("FAIL hold_grid_early: got %0b want 0", pps_out); else passed++;
        tick();
        checks++; if (pps_out !== 1'b1) $display("FAIL hold_second_pps: got %0b want 1", pps_out); else passed++;
        checks++; if (ts_sec_day !== 17'd502) $display("FAIL hold_second_ts: got %0d want 502", ts_sec_day); else passed++;
    endtask

    // Continues from test_holdover: just after the synthesized sec-502 pulse.
    task automatic test_recovery_early();
        int base;
        repeat (994) tick();
        base = pps_cnt;
        pulse(503, 100, 23);
        checks++; if (pps_out !== 1'b1) $display("FAIL early_pps: got %0b want 1", pps_out); else passed++;
        checks++; if (ts_sec_day !== 17'd503) $display("FAIL early_ts: got %0d want 503", ts_sec_day); else passed++;
        checks++; if ({locked, holdover} !== 2'b10) $display("FAIL early_flags: got locked=%0b holdover=%0b want 1/0", locked, holdover); else passed++;
        repeat (20) tick();
        checks++; if (pps_cnt - base !== 1) $display("FAIL early_no_dup: got %0d want 1", pps_cnt - base); else passed++;
    endtask

    task automatic test_recovery_late();
        int base;
        lock_seq(500, 100, 23);
        repeat (3000) tick();
        checks++; if ({pps_out, ts_sec_day} !== {1'b1, 17'd503}) $display("FAIL late_synth: got pps=%0b sec=%0d want 1/503", pps_out, ts_sec_day); else passed++;
        repeat (4) tick();
        base = pps_cnt;
        pulse(503, 100, 23);
        checks++; if (pps_out !== 1'b0) $display("FAIL late_no_extra: got %0b want 0", pps_out); else passed++;
        checks++; if ({locked, holdover} !== 2'b10) $display("FAIL late_flags: got locked=%0b holdover=%0b want 1/0", locked, holdover); else passed++;
        repeat (999) tick();
        pulse(504, 100, 23);
        checks++; if ({pps_out, ts_sec_day} !== {1'b1, 17'd504}) $display("FAIL late_realign: got pps=%0b sec=%0d want 1/504", pps_out, ts_sec_day); else passed++;
        tick();
        checks++; if (pps_cnt - base !== 1) $display("FAIL late_pps_count: got %0d want 1", pps_cnt - base); else passed++;
    endtask

    task automatic test_expiry();
        int base;
        lock_seq(500, 100, 23);
        base = pps_cnt;
        repeat (4000) tick();
        checks++; if ({pps_out, ts_sec_day} !== {1'b1, 17'd504}) $display("FAIL exp_last_synth: got pps=%0b sec=%0d want 1/504", pps_out, ts_sec_day); else passed++;
        repeat (1000) tick();
        checks++; if (pps_out !== 1'b0) $display("FAIL exp_no_pulse: got %0b want 0", pps_out); else passed++;
        checks++; if ({holdover, locked} !== 2'b00) $display("FAIL exp_flags: got holdover=%0b locked=%0b want 0/0", holdover, locked); else passed++;
        repeat (1500) tick();
        checks++; if (pps_cnt - base !== 4) $display("FAIL exp_pps_count: got %0d want 4", pps_cnt - base); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL exp_err: got %0d want 0", err_cnt); else passed++;
    endtask

    task automatic test_rollover();
        int d_in[3] = '{365, 365, 365};
        int y_in[3] = '{23, 24, 99};
        logic [32:0] want[3] = '{{17'd0, 9'd1, 7'd24}, {17'd0, 9'd366, 7'd24}, {17'd0, 9'd1, 7'd0}};
        for (int i = 0; i < 3; i++) begin
            lock_seq(86399, d_in[i], y_in[i]);
            repeat (1010) tick();
            checks++;
            if ({ts_sec_day, ts_day, ts_year} !== want[i])
                $display("FAIL rollover_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, ts_sec_day, ts_day, ts_year,
                         want[i][32:16], want[i][15:7], want[i][6:0]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        lock_seq(500, 100, 23);
        repeat (1999) tick();
        rst = 1'b1;
        tick();
        checks++; if ({pps_out, holdover} !== 2'b00) $display("FAIL midrst_out: got pps=%0b holdover=%0b want 0/0", pps_out, holdover); else passed++;
        rst = 1'b0;
        tick();
        checks++; if (pps_out !== 1'b0) $display("FAIL midrst_after: got %0b want 0", pps_out); else passed++;
        checks++; if ({ts_sec_day, ts_day, ts_year} !== 33'd0) $display("FAIL midrst_ts: got %0d/%0d/%0d want 0/0/0", ts_sec_day, ts_day, ts_year); else passed++;
    endtask

    task automatic test_err_saturate();
        lock_seq(700, 100, 23);
        pps_in = 1'b1;
        ts_sec_day_in = '0;
        repeat (300) tick();
        pps_in = 1'b0;
        checks++; if (err_cnt !== 8'd255) $display("FAIL err_saturate: got %0d want 255", err_cnt); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL err_bad_ignored: got %0b want 1", locked); else passed++;
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_window();
        test_holdover();
        test_recovery_early();
        test_recovery_late();
        test_expiry();
        test_rollover();
        test_reset_mid();
        test_err_saturate();
        tick();
        checks++; if (dbl_cnt !== 0) $display("FAIL pps_double: got %0d want 0", dbl_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
